pw_serial_tx: RTL and testbench
===============================

PW_SERIAL_TX -- requirements
Module: pw_serial_tx

Interface
REQ-001 Parameter BIT_TICKS, default 4: clk_slow cycles per serial bit; legal range 1..255.
REQ-002 clk_slow  input  1  system clock; all logic on its rising edge.
REQ-003 master_rst  input  1  reset, asynchronous, active-low.
REQ-004 send  input  1  request to transmit code; level-sampled, acted on only in IDLE.
REQ-005 code  input  16  4-digit password, 4 bits per digit; digit0 = code[3:0].
REQ-006 tx  output  1  serial line; idles high.
REQ-007 busy  output  1  high while a frame is in progress.
REQ-008 done  output  1  one-cycle pulse when a frame completes.
REQ-009 digit_idx  output  2  index of the digit whose bits are currently on tx; 0 outside DATA.

Function
REQ-010 The frame SHALL be 1 start bit (0), 16 data bits (code[0] first, code[15] last), 1 even-parity bit, and 1 stop bit (1): 19 bits in total.
REQ-011 Parity SHALL make the total count of ones across the 16 data bits plus the parity bit even, computed from the latched code.
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE, when send=1 is sampled on an edge, the block SHALL do all of the following:
- latch code;
- enter START;
- drive busy=1 and tx=0 from the next cycle onward.
REQ-014 Each bit SHALL be held on tx for exactly BIT_TICKS cycles, timed by an internal tick counter cleared at every bit boundary.
REQ-015 DATA SHALL use a 4-bit bit counter:
- bit counter 0..15 selects the latched bit;
- digit_idx = bit counter[3:2];
- after bit 15, the FSM SHALL go to PARITY.
REQ-016 STOP SHALL drive tx=1 for BIT_TICKS cycles and then return to IDLE.
REQ-017 The first IDLE cycle after STOP SHALL have busy=0 and done=1; done SHALL be 0 in all other cycles.
REQ-018 Frame latency from send being sampled to done SHALL be exactly 19*BIT_TICKS+1 cycles.
REQ-019 send while busy=1 SHALL be ignored: no queuing, no restart, no change to the latched code.
REQ-020 Changes on code during a frame SHALL NOT affect tx.
REQ-021 send held high continuously SHALL start a new frame on the edge where done=1, i.e. frames run back-to-back with no idle bit between them.
REQ-022 tx, busy, done and digit_idx SHALL be driven from registers (glitch-free).

Reset
REQ-023 While master_rst=0, the block SHALL hold these values regardless of clk_slow:
- FSM = IDLE;
- tx=1, busy=0, done=0, digit_idx=0;
- tick counter, bit counter and latched code all 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, with tx=1 and no done pulse.
REQ-025 After reset is released, the block SHALL accept send on the first rising edge.

Verification
REQ-026 BIT_TICKS=4, code=16'hA5C3, one-cycle send pulse -> the bench SHALL see all of the following:
- tx = 0 for 4 cycles (start bit);
- data bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, each held 4 cycles;
- parity bit 0;
- stop bit 1;
- done pulse 77 cycles after send is sampled.
REQ-027 code=16'h0001 -> parity bit = 1; the rest of the frame matches REQ-010.
REQ-028 send pulsed again at data bit 5 of a frame -> the frame is unchanged, exactly one done pulse, busy falls only after the stop bit.
REQ-029 send held high with code=16'hFFFF -> two back-to-back frames, each with parity 0; the second start bit begins in the done cycle + 1.
REQ-030 master_rst driven low at data bit 8 -> tx=1, busy=0 in the same cycle, no done pulse; a new send afterwards produces a full, correct frame.
REQ-031 BIT_TICKS=1 -> the frame is 19 cycles with one bit per cycle; digit_idx steps 0,1,2,3 every 4 data cycles.

Source files
------------

// File: rtl/pw_serial_tx.sv
// Serial password transmitter: start bit, 16 code bits LSB first, even parity, stop bit.
// Every output is a register; each bit is held for BIT_TICKS cycles of clk_slow.
module pw_serial_tx #(
  parameter int BIT_TICKS = 4
) (
  input  logic        clk_slow,
  input  logic        master_rst,
  input  logic        send,
  input  logic [15:0] code,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [1:0]  digit_idx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] LAST_TICK = 8'(BIT_TICKS - 1);

  state_t      state_q, state_d;
  logic [7:0]  tick_q, tick_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] code_q, code_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  digit_q, digit_d;

  logic        bit_end;
  logic [3:0]  bit_nxt;

  assign bit_end = (tick_q == LAST_TICK);
  assign bit_nxt = bit_q + 4'd1;

  always_ff @(posedge clk_slow or negedge master_rst) begin
    if (!master_rst) begin
      state_q <= IDLE;
      tick_q  <= 8'd0;
      bit_q   <= 4'd0;
      code_q  <= 16'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      digit_q <= 2'd0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      code_q  <= code_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      digit_q <= digit_d;
    end
  end

  // Outputs are computed one cycle ahead so that they change together with the state.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    code_d  = code_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    digit_d = digit_q;

    if (state_q != IDLE) begin
      tick_d = bit_end ? 8'd0 : tick_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        digit_d = 2'd0;
        tick_d  = 8'd0;
        bit_d   = 4'd0;
        if (send) begin
          code_d  = code;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 4'd0;
          tx_d    = code_q[0];
          digit_d = 2'd0;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == 4'd15) begin
            state_d = PARITY;
            tx_d    = ^code_q;
            digit_d = 2'd0;
          end else begin
            bit_d   = bit_nxt;
            tx_d    = code_q[bit_nxt];
            digit_d = bit_nxt[3:2];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          // The done cycle is a normal IDLE cycle, so a held send restarts on its edge.
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bit_d   = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        digit_d = 2'd0;
      end
    endcase
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign digit_idx = digit_q;

endmodule

// File: tb/tb_pw_serial_tx.sv
// Bench for pw_serial_tx with BIT_TICKS=4 and BIT_TICKS=1 instances.
// A frame-level model pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_pw_serial_tx;

  typedef struct packed {
    logic       tx;
    logic       busy;
    logic       done;
    logic [1:0] dig;
  } exp_t;

  localparam exp_t IDLE_E = '{tx: 1'b1, busy: 1'b0, done: 1'b0, dig: 2'd0};

  logic clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  logic        rst4_n, send4, tx4, busy4, done4;
  logic [15:0] code4;
  logic [1:0]  dig4;
  logic        rst1_n, send1, tx1, busy1, done1;
  logic [15:0] code1;
  logic [1:0]  dig1;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc4 = 0;
  int   acc1 = 0;
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, a4, e1, a1;

  pw_serial_tx #(.BIT_TICKS(4)) dut4 (
    .clk_slow(clk_slow), .master_rst(rst4_n), .send(send4), .code(code4),
    .tx(tx4), .busy(busy4), .done(done4), .digit_idx(dig4)
  );

  pw_serial_tx #(.BIT_TICKS(1)) dut1 (
    .clk_slow(clk_slow), .master_rst(rst1_n), .send(send1), .code(code1),
    .tx(tx1), .busy(busy1), .done(done1), .digit_idx(dig1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame = start 0, code bits LSB first, even parity, stop 1; then one done cycle.
  task automatic push_frame(input int inst, input logic [15:0] c);
    int         bt;
    logic       b;
    logic [1:0] d;
    exp_t       e;
    bt = (inst == 0) ? 4 : 1;
    for (int i = 0; i < 19; i++) begin
      if (i == 0)       b = 1'b0;
      else if (i <= 16) b = c[i-1];
      else if (i == 17) b = ^c;
      else              b = 1'b1;
      d = (i >= 1 && i <= 16) ? 2'((i - 1) / 4) : 2'd0;
      e = '{tx: b, busy: 1'b1, done: 1'b0, dig: d};
      for (int k = 0; k < bt; k++) begin
        if (inst == 0) q4.push_back(e);
        else           q1.push_back(e);
      end
    end
    e = '{tx: 1'b1, busy: 1'b0, done: 1'b1, dig: 2'd0};
    if (inst == 0) q4.push_back(e);
    else           q1.push_back(e);
  endtask

  // Model: a request is taken only when no frame (including its done cycle) is pending.
  always @(posedge clk_slow) begin
    cyc = cyc + 1;
    if (rst4_n === 1'b1 && send4 === 1'b1 && q4.size() == 0) begin
      push_frame(0, code4);
      acc4 = cyc;
    end
    if (rst1_n === 1'b1 && send1 === 1'b1 && q1.size() == 0) begin
      push_frame(1, code1);
      acc1 = cyc;
    end
  end

  always @(negedge clk_slow) begin
    if (q4.size() != 0) e4 = q4.pop_front();
    else                e4 = IDLE_E;
    a4 = {tx4, busy4, done4, dig4};
    chk("bt4_outputs{tx,busy,done,digit}", int'(a4), int'(e4));
    if (e4.done && done4 === 1'b1) chk("bt4_latency", cyc - acc4 + 1, 19 * 4 + 1);
    if (q1.size() != 0) e1 = q1.pop_front();
    else                e1 = IDLE_E;
    a1 = {tx1, busy1, done1, dig1};
    chk("bt1_outputs{tx,busy,done,digit}", int'(a1), int'(e1));
    if (e1.done && done1 === 1'b1) chk("bt1_latency", cyc - acc1 + 1, 19 * 1 + 1);
  end

  task automatic wait_idle(input int inst);
    int n;
    n = 0;
    while (((inst == 0) ? q4.size() : q1.size()) != 0 && n < 2000) begin
      @(posedge clk_slow);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle inst %0d: frame still pending after %0d cycles", inst, n);
    end
    @(posedge clk_slow);
    #2;
  endtask

  task automatic pulse4(input logic [15:0] c);
    @(posedge clk_slow);
    #2;
    code4 = c;
    send4 = 1'b1;
    @(posedge clk_slow);
    #2;
    send4 = 1'b0;
  endtask

  task automatic pulse1(input logic [15:0] c);
    @(posedge clk_slow);
    #2;
    code1 = c;
    send1 = 1'b1;
    @(posedge clk_slow);
    #2;
    send1 = 1'b0;
  endtask

  initial begin
    rst4_n = 1'b0; send4 = 1'b0; code4 = 16'h0;
    rst1_n = 1'b0; send1 = 1'b0; code1 = 16'h0;
    repeat (3) @(posedge clk_slow);
    #2;
    chk("reset_bt4", int'({tx4, busy4, done4, dig4}), int'(IDLE_E));
    chk("reset_bt1", int'({tx1, busy1, done1, dig1}), int'(IDLE_E));

    // Release and request in the same cycle: the first edge must accept.
    rst4_n = 1'b1; rst1_n = 1'b1;
    code4 = 16'hA5C3; send4 = 1'b1;
    @(posedge clk_slow);
    #2;
    send4 = 1'b0;
    chk("first_edge_accept_busy", int'(busy4), 1);
    wait_idle(0);

    pulse4(16'h0001);
    wait_idle(0);

    // Second request at data bit 5 plus code churn during the frame.
    pulse4(16'h3C5A);
    repeat (23) @(posedge clk_slow);
    #2;
    send4 = 1'b1;
    code4 = 16'hFFFF;
    @(posedge clk_slow);
    #2;
    send4 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_slow);
      #2;
      code4 = 16'($urandom);
    end
    wait_idle(0);

    // Held send: two back-to-back frames.
    code4 = 16'hFFFF;
    send4 = 1'b1;
    repeat (90) @(posedge clk_slow);
    #2;
    send4 = 1'b0;
    wait_idle(0);

    // Reset during data bit 8.
    pulse4(16'h5A5A);
    repeat (36) @(posedge clk_slow);
    #1;
    chk("bt4_digit_before_reset", int'(dig4), 2);
    rst4_n = 1'b0;
    q4.delete();
    #1;
    chk("abort_tx", int'(tx4), 1);
    chk("abort_busy", int'(busy4), 0);
    chk("abort_done", int'(done4), 0);
    repeat (3) @(posedge clk_slow);
    #2;
    rst4_n = 1'b1;
    pulse4(16'hBEEF);
    wait_idle(0);

    // Random frames with stray requests and code churn mid-frame.
    for (int f = 0; f < 8; f++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk_slow);
      pulse4(16'($urandom));
      for (int n = 0; n < 200 && q4.size() != 0; n++) begin
        @(posedge clk_slow);
        #2;
        send4 = ($urandom_range(0, 7) == 0);
        code4 = 16'($urandom);
      end
      send4 = 1'b0;
      wait_idle(0);
    end

    // Single-tick bits.
    pulse1(16'hA5C3);
    wait_idle(1);
    for (int f = 0; f < 4; f++) begin
      pulse1(16'($urandom));
      wait_idle(1);
    end
    send1 = 1'b1;
    for (int i = 0; i < 70; i++) begin
      code1 = 16'($urandom);
      @(posedge clk_slow);
      #2;
    end
    send1 = 1'b0;
    wait_idle(1);

    repeat (5) @(posedge clk_slow);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
